// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point add/subtract: align, add/normalise, round/pack.
// Subnormals flush to signed zero; rounding is round-to-nearest-even.
module fp_addsub_pipe #(
  parameter int  EXP_W = 8,
  parameter int  MAN_W = 23,
  localparam int FW    = 1 + EXP_W + MAN_W
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          op_valid_i,
  output logic          op_ready_o,
  input  logic [FW-1:0] op_a_i,
  input  logic [FW-1:0] op_b_i,
  input  logic          op_sub_i,
  output logic          sum_valid_o,
  input  logic          sum_ready_i,
  output logic [FW-1:0] sum_data_o,
  output logic [3:0]    sum_flags_o
);
  localparam int SW  = MAN_W + 4;
  localparam int LZW = $clog2(SW + 1);
  localparam int XW  = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [MAN_W-1:0] MAN_ZERO = {MAN_W{1'b0}};
  localparam logic [XW-1:0]    XONE     = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [FW-1:0]    QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = {LZW{1'b0}};
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found && !v[i]) n = n + {{(LZW-1){1'b0}}, 1'b1};
      else found = 1'b1;
    end
    return n;
  endfunction

  logic ready1_s, ready2_s, ready3_s;
  logic s1_valid_r, s2_valid_r, s3_valid_r;

  // Operand decode; B's sign is inverted at entry for subtraction.
  logic             sa_s, sb_s, za_s, zb_s, a_ge_s;
  logic             nan_a_s, nan_b_s, inf_a_s, inf_b_s;
  logic [EXP_W-1:0] ea_s, eb_s;
  logic [MAN_W-1:0] ma_s, mb_s;
  logic [MAN_W:0]   ga_s, gb_s;
  assign sa_s    = op_a_i[FW-1];
  assign sb_s    = op_b_i[FW-1] ^ op_sub_i;
  assign ea_s    = op_a_i[FW-2:MAN_W];
  assign eb_s    = op_b_i[FW-2:MAN_W];
  assign ma_s    = op_a_i[MAN_W-1:0];
  assign mb_s    = op_b_i[MAN_W-1:0];
  assign za_s    = (ea_s == EXP_ZERO);
  assign zb_s    = (eb_s == EXP_ZERO);
  assign ga_s    = za_s ? {(MAN_W+1){1'b0}} : {1'b1, ma_s};
  assign gb_s    = zb_s ? {(MAN_W+1){1'b0}} : {1'b1, mb_s};
  assign nan_a_s = (ea_s == EXP_ONES) && (ma_s != MAN_ZERO);
  assign nan_b_s = (eb_s == EXP_ONES) && (mb_s != MAN_ZERO);
  assign inf_a_s = (ea_s == EXP_ONES) && (ma_s == MAN_ZERO);
  assign inf_b_s = (eb_s == EXP_ONES) && (mb_s == MAN_ZERO);
  assign a_ge_s  = {ea_s, ga_s[MAN_W-1:0]} >= {eb_s, gb_s[MAN_W-1:0]};

  logic          spec_s;
  logic [FW-1:0] spec_data_s;
  logic [3:0]    spec_flags_s;
  // Special-operand priority: NaN, then inf-inf, then a single infinity.
  always_comb begin
    spec_s       = 1'b1;
    spec_data_s  = QNAN;
    spec_flags_s = 4'b0000;
    if (nan_a_s || nan_b_s) begin
      spec_data_s = QNAN;
    end else if (inf_a_s && inf_b_s && (sa_s != sb_s)) begin
      spec_flags_s = 4'b1000;
    end else if (inf_a_s || inf_b_s) begin
      spec_data_s = {(inf_a_s ? sa_s : sb_s), EXP_ONES, MAN_ZERO};
    end else begin
      spec_s = 1'b0;
    end
  end

  logic             sx_s;
  logic [EXP_W-1:0] ex_s, ey_s, diff_s;
  logic [MAN_W:0]   gx_s, gy_s;
  logic [SW-1:0]    y_ext_s, y_mask_s, y_al_s;
  // Swap so X is the larger magnitude, then align Y keeping guard/round/sticky.
  always_comb begin
    if (a_ge_s) begin
      sx_s = sa_s; ex_s = ea_s; ey_s = eb_s; gx_s = ga_s; gy_s = gb_s;
    end else begin
      sx_s = sb_s; ex_s = eb_s; ey_s = ea_s; gx_s = gb_s; gy_s = ga_s;
    end
    diff_s   = ex_s - ey_s;
    y_ext_s  = {gy_s, 3'b000};
    y_mask_s = ~({SW{1'b1}} << diff_s);
    y_al_s   = (y_ext_s >> diff_s) | {{(SW-1){1'b0}}, |(y_ext_s & y_mask_s)};
  end

  assign ready3_s   = !s3_valid_r || sum_ready_i;
  assign ready2_s   = !s2_valid_r || ready3_s;
  assign ready1_s   = !s1_valid_r || ready2_s;
  assign op_ready_o = ready1_s;

  logic             s1_sign_r, s1_sub_r, s1_zsign_r, s1_spec_r;
  logic [EXP_W-1:0] s1_exp_r;
  logic [SW-1:0]    s1_sigx_r, s1_sigy_r;
  logic [FW-1:0]    s1_spec_data_r;
  logic [3:0]       s1_spec_flags_r;
  // Stage 1 register: aligned operands and decoded specials.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_r <= 1'b0; s1_sign_r <= 1'b0; s1_sub_r <= 1'b0; s1_zsign_r <= 1'b0;
      s1_spec_r <= 1'b0; s1_exp_r <= EXP_ZERO; s1_sigx_r <= {SW{1'b0}};
      s1_sigy_r <= {SW{1'b0}}; s1_spec_data_r <= {FW{1'b0}}; s1_spec_flags_r <= 4'b0000;
    end else if (ready1_s) begin
      s1_valid_r <= op_valid_i; s1_sign_r <= sx_s; s1_sub_r <= sa_s ^ sb_s;
      s1_zsign_r <= sa_s & sb_s; s1_spec_r <= spec_s; s1_exp_r <= ex_s;
      s1_sigx_r <= {gx_s, 3'b000}; s1_sigy_r <= y_al_s;
      s1_spec_data_r <= spec_data_s; s1_spec_flags_r <= spec_flags_s;
    end
  end

  logic [SW:0]     sum_s;
  logic [LZW-1:0]  lz_s;
  logic [SW-1:0]   norm_sig_s;
  logic [XW-1:0]   norm_exp_s;
  // Add/subtract magnitudes, then normalise (carry right-shift or LZC left-shift).
  always_comb begin
    if (s1_sub_r) sum_s = {1'b0, s1_sigx_r} - {1'b0, s1_sigy_r};
    else          sum_s = {1'b0, s1_sigx_r} + {1'b0, s1_sigy_r};
    lz_s = lzc(sum_s[SW-1:0]);
    if (sum_s[SW]) begin
      norm_sig_s = {sum_s[SW:2], sum_s[1] | sum_s[0]};
      norm_exp_s = {2'b00, s1_exp_r} + XONE;
    end else begin
      norm_sig_s = sum_s[SW-1:0] << lz_s;
      norm_exp_s = {2'b00, s1_exp_r} - {{(XW-LZW){1'b0}}, lz_s};
    end
  end

  logic          s2_sign_r, s2_zero_r, s2_zsign_r, s2_spec_r;
  logic [XW-1:0] s2_exp_r;
  logic [SW-1:0] s2_sig_r;
  logic [FW-1:0] s2_spec_data_r;
  logic [3:0]    s2_spec_flags_r;
  // Stage 2 register: normalised significand with signed, widened exponent.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_r <= 1'b0; s2_sign_r <= 1'b0; s2_zero_r <= 1'b0; s2_zsign_r <= 1'b0;
      s2_spec_r <= 1'b0; s2_exp_r <= {XW{1'b0}}; s2_sig_r <= {SW{1'b0}};
      s2_spec_data_r <= {FW{1'b0}}; s2_spec_flags_r <= 4'b0000;
    end else if (ready2_s) begin
      s2_valid_r <= s1_valid_r; s2_sign_r <= s1_sign_r; s2_zero_r <= (sum_s == {(SW+1){1'b0}});
      s2_zsign_r <= s1_zsign_r; s2_spec_r <= s1_spec_r; s2_exp_r <= norm_exp_s;
      s2_sig_r <= norm_sig_s; s2_spec_data_r <= s1_spec_data_r; s2_spec_flags_r <= s1_spec_flags_r;
    end
  end

  logic             rnd_up_s, inx_s;
  logic [MAN_W+1:0] rsum_s;
  logic [MAN_W-1:0] rman_s;
  logic [XW-1:0]    rexp_s;
  logic [FW-1:0]    res_data_s;
  logic [3:0]       res_flags_s;
  // Round to nearest even, renormalise on rounding carry, then pack with flags.
  always_comb begin
    rnd_up_s = s2_sig_r[2] & (s2_sig_r[1] | s2_sig_r[0] | s2_sig_r[3]);
    inx_s    = |s2_sig_r[2:0];
    rsum_s   = {1'b0, s2_sig_r[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up_s};
    if (rsum_s[MAN_W+1]) begin
      rman_s = rsum_s[MAN_W:1];
      rexp_s = s2_exp_r + XONE;
    end else begin
      rman_s = rsum_s[MAN_W-1:0];
      rexp_s = s2_exp_r;
    end
    if (s2_spec_r) begin
      res_data_s  = s2_spec_data_r;
      res_flags_s = s2_spec_flags_r;
    end else if (s2_zero_r) begin
      res_data_s  = {s2_zsign_r, EXP_ZERO, MAN_ZERO};
      res_flags_s = 4'b0000;
    end else if ($signed(rexp_s) >= $signed({2'b00, EXP_ONES})) begin
      res_data_s  = {s2_sign_r, EXP_ONES, MAN_ZERO};
      res_flags_s = 4'b0101;
    end else if ($signed(rexp_s) <= $signed({XW{1'b0}})) begin
      res_data_s  = {s2_sign_r, EXP_ZERO, MAN_ZERO};
      res_flags_s = 4'b0011;
    end else begin
      res_data_s  = {s2_sign_r, rexp_s[EXP_W-1:0], rman_s};
      res_flags_s = {3'b000, inx_s};
    end
  end

  logic [FW-1:0] s3_data_r;
  logic [3:0]    s3_flags_r;
  // Stage 3 register: packed result, held while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s3_valid_r <= 1'b0;
      s3_data_r  <= {FW{1'b0}};
      s3_flags_r <= 4'b0000;
    end else if (ready3_s) begin
      s3_valid_r <= s2_valid_r;
      s3_data_r  <= res_data_s;
      s3_flags_r <= res_flags_s;
    end
  end

  assign sum_valid_o = s3_valid_r;
  assign sum_data_o  = s3_data_r;
  assign sum_flags_o = s3_flags_r;
endmodule
